speed_meter_mux: RTL and testbench
==================================

SPEED_METER_MUX -- requirements
Module: speed_meter_mux

Interface
REQ-001 Parameter DIST_W, 14, width of distance input in cm.
REQ-002 Parameter DIGITS, 4, number of multiplexed 7-segment digits (2..6).
REQ-003 Parameter TICK_DIV, 50000, clk cycles per 1 ms tick (≥2).
REQ-004 Parameter WIN_MS, 100, measurement window in ms; SHALL divide 1000 exactly.
REQ-005 Parameter SCAN_CYC, 50000, clk cycles each digit is driven (≥2).
REQ-006 clk  input  1  single system clock; all logic rising-edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 key  input  1  start/stop request, level, already debounced; asynchronous to clk.
REQ-009 mode  input  1  0 = single-shot, 1 = continuous repeat.
REQ-010 distance  input  DIST_W  current range in cm, unsigned, stable ≥1 cycle.
REQ-011 led  output  3  [0] measuring, [1] approaching, [2] receding or overflow.
REQ-012 sel  output  DIGITS  digit enable, one-hot active-low, bit 0 = least significant digit.
REQ-013 seg  output  8  segments active-low, {dp,g,f,e,d,c,b,a}; dp always 1.

Function
REQ-014 key SHALL pass a 2-flop synchroniser; only its rising edge (key_rise, 1 cycle) acts.
REQ-015 FSM states IDLE, CAP0, WAIT, CAP1, CALC, CONV; reset state IDLE.
REQ-016 IDLE→CAP0 on key_rise; CAP0 latches d0=distance, →WAIT, clears tick and ms counters.
REQ-017 WAIT counts ms ticks; after WIN_MS ticks (WIN_MS*TICK_DIV cycles after CAP0) →CAP1.
REQ-018 CAP1 latches d1=distance, →CALC; CALC computes delta=|d1-d0|, dir=sign, speed=delta*(1000/WIN_MS) cm/s, →CONV.
REQ-019 speed ≥ 10^DIGITS SHALL saturate to 10^DIGITS-1 and set overflow flag.
REQ-020 CONV starts bin2bcd_seq; on done the display BCD register updates atomically in one cycle; latency CAP1→display ≤ 2+SPD_W+2 cycles, SPD_W = speed width.
REQ-021 After CONV: mode=0 →IDLE; mode=1 →CAP0 (next window begins, d0 taken freshly).
REQ-022 key_rise outside IDLE SHALL abort to IDLE; display keeps last completed result.
REQ-023 led[0]=1 in every state except IDLE; led[1]=1 iff last d1<d0; led[2]=1 iff last d1>d0 or overflow; d1==d0 gives led[2:1]=00, display 0.
REQ-024 Scanner: sel rotates 0→1→…→DIGITS-1→0, SCAN_CYC cycles per digit, free-running from reset; seg decodes the selected BCD digit; leading zeros shown.
REQ-025 Display during first measurement after reset SHALL read all zeros.

Reset
REQ-026 rst SHALL return FSM to IDLE, clear d0, d1, counters, synchroniser, BCD register, flags, averaging history.
REQ-027 Reset outputs: led=3'b000, sel=all ones, seg=8'hFF; first digit driven the cycle after rst deasserts.
REQ-028 rst mid-WAIT or mid-CONV SHALL discard the measurement; no partial display update.

Configuration
REQ-029 Macro SPEED_AVG_EN defined: displayed speed = (sum of last 4 saturated results)>>2; the first result after reset or mode change fills all 4 slots; led[1]/[2] follow the latest result.
REQ-030 SPEED_AVG_EN undefined: the latest result is displayed directly; no history registers exist.

Structure
REQ-031 Package speed_pkg SHALL hold the FSM state enum, 7-segment digit-to-pattern table (0-9, blank=8'hFF) and the SEG_OFF constant.
REQ-032 One sub-module bin2bcd_seq (sequential double-dabble, start/done handshake, parametrised binary and digit width); all else in speed_meter_mux.

Verification
REQ-033 TICK_DIV=4, WIN_MS=100; key pulse, distance 500 then 380 at CAP1 → display 1200, led=3'b011.
REQ-034 distance 200 then 260 → display 0600, led=3'b101; equal 300/300 → 0000, led[2:1]=00.
REQ-035 distance 0 then 16383 (DIGITS=4) → display 9999, led[2]=1 (overflow).
REQ-036 mode=1, distances 100/110/120/130 per window → continuous updates 0100, 0100, 0100; key pulse mid-WAIT → IDLE, led[0]=0, display holds 0100.
REQ-037 rst asserted during CONV → led=0, sel=all ones, seg=8'hFF next cycle; next measurement displays correctly.
REQ-038 SPEED_AVG_EN, results 400,800,800,800 → displays 0400, 0500, 0600, 0700.

Source files
------------

// File: rtl/speed_pkg.sv
// Shared types and constants for the speed meter: FSM state encoding and the
// active-low 7-segment pattern table ({dp,g,f,e,d,c,b,a}, dp held off).
package speed_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CAP0 = 3'd1,
        ST_WAIT = 3'd2,
        ST_CAP1 = 3'd3,
        ST_CALC = 3'd4,
        ST_CONV = 3'd5
    } state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Any code outside 0..9 blanks the digit
    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        logic [7:0] pat;
        case (digit)
            4'd0:    pat = 8'hC0;
            4'd1:    pat = 8'hF9;
            4'd2:    pat = 8'hA4;
            4'd3:    pat = 8'hB0;
            4'd4:    pat = 8'h99;
            4'd5:    pat = 8'h92;
            4'd6:    pat = 8'h82;
            4'd7:    pat = 8'hF8;
            4'd8:    pat = 8'h80;
            4'd9:    pat = 8'h90;
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle after a start pulse,
// done pulses for one cycle while bcd holds the finished result.
module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0]    shift_r;
    logic [4*DIGITS-1:0] bcd_r;
    logic [4*DIGITS-1:0] adj_s;
    logic [CNT_W-1:0]    cnt_r;
    logic                busy_r;
    logic                done_r;

    function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Pre-shift correction of every BCD nibble
    always_comb begin
        adj_s = add3(bcd_r);
    end

    // Shift engine: MSB of the binary word enters the BCD field each cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r <= '0;
            bcd_r   <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (start) begin
            shift_r <= bin;
            bcd_r   <= '0;
            cnt_r   <= CNT_W'(BIN_W);
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
        end else if (busy_r) begin
            bcd_r   <= {adj_s[4*DIGITS-2:0], shift_r[BIN_W-1]};
            shift_r <= {shift_r[BIN_W-2:0], 1'b0};
            cnt_r   <= cnt_r - CNT_W'(1);
            busy_r  <= (cnt_r != CNT_W'(1));
            done_r  <= (cnt_r == CNT_W'(1));
        end else begin
            done_r  <= 1'b0;
        end
    end

    assign done = done_r;
    assign bcd  = bcd_r;

endmodule

// File: rtl/speed_meter_mux.sv
// Speed meter: two distance samples one window apart give a speed in cm/s,
// shown on a multiplexed 7-segment display. Optional SPEED_AVG_EN macro
// displays the mean of the last four results instead of the latest one.
module speed_meter_mux
    import speed_pkg::*;
#(
    parameter int DIST_W   = 14,
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000,
    parameter int WIN_MS   = 100,
    parameter int SCAN_CYC = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key,
    input  logic              mode,
    input  logic [DIST_W-1:0] distance,
    output logic [2:0]        led,
    output logic [DIGITS-1:0] sel,
    output logic [7:0]        seg
);

    localparam int MULT   = 1000 / WIN_MS;
    localparam int LIMIT  = 10 ** DIGITS;
    localparam int SAT_W  = $clog2(LIMIT);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int MS_W   = $clog2(WIN_MS + 1);
    localparam int SCAN_W = $clog2(SCAN_CYC);
    localparam int IDX_W  = $clog2(DIGITS);

    state_t              state_r, state_nxt_s;
    logic [2:0]          key_sync_r;
    logic                key_rise_s;
    logic [TICK_W-1:0]   tick_cnt_r;
    logic [MS_W-1:0]     ms_cnt_r;
    logic                tick_last_s, ms_last_s;
    logic [DIST_W-1:0]   d0_r, d1_r, delta_s;
    logic [31:0]         speed_s;
    logic                ovf_s;
    logic [SAT_W-1:0]    sat_s, conv_bin_s;
    logic                conv_start_s, conv_done_s, commit_s;
    logic [BCD_W-1:0]    conv_bcd_s, disp_bcd_r;
    logic                pend_appr_r, pend_rec_r, appr_r, rec_r;
    logic [2:0]          led_nxt_s;
    logic [SCAN_W-1:0]   scan_cnt_r;
    logic [IDX_W-1:0]    digit_idx_r;

    // Key synchroniser plus edge-detect flop
    always_ff @(posedge clk) begin
        if (rst) begin
            key_sync_r <= 3'b000;
        end else begin
            key_sync_r <= {key_sync_r[1:0], key};
        end
    end
    assign key_rise_s = key_sync_r[1] & ~key_sync_r[2];

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; a key press anywhere but IDLE abandons the measurement
    always_comb begin
        state_nxt_s = state_r;
        if (key_rise_s && (state_r != ST_IDLE)) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = key_rise_s ? ST_CAP0 : ST_IDLE;
                ST_CAP0: state_nxt_s = ST_WAIT;
                ST_WAIT: state_nxt_s = (tick_last_s && ms_last_s) ? ST_CAP1 : ST_WAIT;
                ST_CAP1: state_nxt_s = ST_CALC;
                ST_CALC: state_nxt_s = ST_CONV;
                ST_CONV: begin
                    if (conv_done_s) begin
                        state_nxt_s = mode ? ST_CAP0 : ST_IDLE;
                    end else begin
                        state_nxt_s = ST_CONV;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs and counter terminal conditions
    always_comb begin
        tick_last_s  = (tick_cnt_r == TICK_W'(TICK_DIV - 1));
        ms_last_s    = (ms_cnt_r == MS_W'(WIN_MS - 1));
        conv_start_s = (state_r == ST_CALC);
        commit_s     = (state_r == ST_CONV) && conv_done_s && !key_rise_s;
        led_nxt_s    = {rec_r, appr_r, (state_r != ST_IDLE)};
    end

    // Speed from the two samples, saturated to what the display can show
    always_comb begin
        if (d1_r >= d0_r) begin
            delta_s = d1_r - d0_r;
        end else begin
            delta_s = d0_r - d1_r;
        end
        speed_s = 32'(delta_s) * 32'(MULT);
        ovf_s   = (speed_s >= 32'(LIMIT));
        if (ovf_s) begin
            sat_s = SAT_W'(LIMIT - 1);
        end else begin
            sat_s = speed_s[SAT_W-1:0];
        end
    end

    // Window timing, sample capture and atomic display commit
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r  <= '0;
            ms_cnt_r    <= '0;
            d0_r        <= '0;
            d1_r        <= '0;
            pend_appr_r <= 1'b0;
            pend_rec_r  <= 1'b0;
            appr_r      <= 1'b0;
            rec_r       <= 1'b0;
            disp_bcd_r  <= '0;
        end else begin
            if (state_r == ST_CAP0) begin
                d0_r       <= distance;
                tick_cnt_r <= '0;
                ms_cnt_r   <= '0;
            end else if (state_r == ST_WAIT) begin
                if (tick_last_s) begin
                    tick_cnt_r <= '0;
                    ms_cnt_r   <= ms_cnt_r + MS_W'(1);
                end else begin
                    tick_cnt_r <= tick_cnt_r + TICK_W'(1);
                end
            end
            if (state_r == ST_CAP1) begin
                d1_r <= distance;
            end
            if (state_r == ST_CALC) begin
                pend_appr_r <= (d1_r < d0_r);
                pend_rec_r  <= (d1_r > d0_r) || ovf_s;
            end
            if (commit_s) begin
                disp_bcd_r <= conv_bcd_s;
                appr_r     <= pend_appr_r;
                rec_r      <= pend_rec_r;
            end
        end
    end

`ifdef SPEED_AVG_EN
    logic [SAT_W-1:0] hist_r [3];
    logic             hist_valid_r, hist_mode_r;
    logic             refill_s, pend_refill_r, pend_mode_r;
    logic [SAT_W-1:0] pend_sat_r;
    logic [SAT_W+1:0] sum_s;

    // Mean of the newest result and the three committed before it
    always_comb begin
        refill_s = !hist_valid_r || (mode != hist_mode_r);
        sum_s    = {2'b00, sat_s} + {2'b00, hist_r[0]} + {2'b00, hist_r[1]} + {2'b00, hist_r[2]};
        if (refill_s) begin
            conv_bin_s = sat_s;
        end else begin
            conv_bin_s = SAT_W'(sum_s >> 2);
        end
    end

    // History only advances when a result reaches the display
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                hist_r[i] <= '0;
            end
            hist_valid_r  <= 1'b0;
            hist_mode_r   <= 1'b0;
            pend_refill_r <= 1'b0;
            pend_mode_r   <= 1'b0;
            pend_sat_r    <= '0;
        end else begin
            if (state_r == ST_CALC) begin
                pend_sat_r    <= sat_s;
                pend_refill_r <= refill_s;
                pend_mode_r   <= mode;
            end
            if (commit_s) begin
                if (pend_refill_r) begin
                    for (int i = 0; i < 3; i++) begin
                        hist_r[i] <= pend_sat_r;
                    end
                end else begin
                    hist_r[2] <= hist_r[1];
                    hist_r[1] <= hist_r[0];
                    hist_r[0] <= pend_sat_r;
                end
                hist_valid_r <= 1'b1;
                hist_mode_r  <= pend_mode_r;
            end
        end
    end
`else
    assign conv_bin_s = sat_s;
`endif

    bin2bcd_seq #(
        .BIN_W  (SAT_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start_s),
        .bin   (conv_bin_s),
        .done  (conv_done_s),
        .bcd   (conv_bcd_s)
    );

    // Free-running digit scanner with registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_r  <= '0;
            digit_idx_r <= '0;
            sel         <= '1;
            seg         <= SEG_OFF;
            led         <= 3'b000;
        end else begin
            sel <= ~(DIGITS'(1) << digit_idx_r);
            seg <= seg_decode(disp_bcd_r[4*digit_idx_r +: 4]);
            led <= led_nxt_s;
            if (scan_cnt_r == SCAN_W'(SCAN_CYC - 1)) begin
                scan_cnt_r <= '0;
                if (digit_idx_r == IDX_W'(DIGITS - 1)) begin
                    digit_idx_r <= '0;
                end else begin
                    digit_idx_r <= digit_idx_r + IDX_W'(1);
                end
            end else begin
                scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_speed_meter_mux.sv
// Self-checking bench for speed_meter_mux: table-driven single measurements,
// continuous-mode sequences and reset-during-conversion, with a result queue.
module tb_speed_meter_mux;

    localparam int DIST_W   = 14;
    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 4;
    localparam int WIN_MS   = 100;
    localparam int SCAN_CYC = 2;
    // Nominal spacing of successive windows in continuous mode; stimulus sits
    // far enough from window edges that small latency differences do not matter
    localparam int PERIOD   = 418;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              key = 1'b0;
    logic              mode = 1'b0;
    logic [DIST_W-1:0] distance = '0;
    logic [2:0]        led;
    logic [DIGITS-1:0] sel;
    logic [7:0]        seg;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct { int disp; int led; } exp_t;
    typedef struct { int d0; int d1; int m; int speed; int led; } vec_t;

    exp_t sb_q[$];
    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

`ifdef SPEED_AVG_EN
    int m_hist[4];
    bit m_valid = 1'b0;
    bit m_mode  = 1'b0;
`endif

    speed_meter_mux #(
        .DIST_W   (DIST_W),
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV),
        .WIN_MS   (WIN_MS),
        .SCAN_CYC (SCAN_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .mode     (mode),
        .distance (distance),
        .led      (led),
        .sel      (sel),
        .seg      (seg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Displayed value: averaging model when enabled, else the raw result
    function automatic int model_display(input int raw);
`ifdef SPEED_AVG_EN
        int s;
        if (!m_valid || (m_mode != mode)) begin
            for (int i = 0; i < 4; i++) m_hist[i] = raw;
        end else begin
            m_hist[3] = m_hist[2];
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = raw;
        end
        m_valid = 1'b1;
        m_mode  = mode;
        s = m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3];
        return s / 4;
`else
        return raw;
`endif
    endfunction

    function automatic int raw_speed(input int d0, input int d1);
        int d;
        d = (d1 >= d0) ? (d1 - d0) : (d0 - d1);
        d = d * (1000 / WIN_MS);
        return (d > 9999) ? 9999 : d;
    endfunction

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Reset pulse with checks of the reset state and the first scanned digit
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        key = 1'b0;
        @(negedge clk);
        check("rst_led", int'(led), 0);
        check("rst_sel", int'(sel), 15);
        check("rst_seg", int'(seg), 255);
        rst = 1'b0;
        @(negedge clk);
        check("first_sel", int'(sel), 14);
        check("first_seg", int'(seg), 192);
`ifdef SPEED_AVG_EN
        m_valid = 1'b0;
`endif
    endtask

    // Decode one full scan of the display; -1 for anything undecodable
    task automatic read_display(output int val);
        int dig[DIGITS];
        bit seen[DIGITS];
        bit bad;
        int idx, dv, p;
        logic [DIGITS-1:0] msk;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            dig[i] = 0;
            seen[i] = 1'b0;
        end
        repeat (DIGITS * SCAN_CYC * 2) begin
            @(negedge clk);
            idx = -1;
            dv = -1;
            for (int i = 0; i < DIGITS; i++) begin
                msk = '1;
                msk[i] = 1'b0;
                if (sel == msk) idx = i;
            end
            for (int v = 0; v < 10; v++) begin
                if (seg == seg_tab[v]) dv = v;
            end
            if (idx < 0 || dv < 0) begin
                bad = 1'b1;
            end else begin
                dig[idx] = dv;
                seen[idx] = 1'b1;
            end
        end
        val = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!seen[i]) bad = 1'b1;
            val += dig[i] * p;
            p *= 10;
        end
        if (bad) val = -1;
    endtask

    // Raise key and wait (bounded) until the meter reports measuring
    task automatic start_meas(output int c1);
        bit seen;
        seen = 1'b0;
        key = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (led[0] == 1'b1) seen = 1'b1;
        end
        c1 = cyc;
        key = 1'b0;
        if (!seen) check("start_timeout_led0", int'(led[0]), 1);
    endtask

    task automatic abort_key();
        key = 1'b1;
        repeat (4) @(negedge clk);
        key = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_compare(input string tag);
        int v;
        exp_t e;
        read_display(v);
        if (sb_q.size() == 0) begin
            check({tag, "_queue_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_disp"}, v, e.disp);
            check({tag, "_led"}, int'(led), e.led);
        end
    endtask

    // Continuous mode: distance steps once per window, then abort mid-WAIT
    task automatic run_cont(input string tag, input int dl[5], input int nwin);
        int c1, v, last;
        exp_t e;
        do_reset();
        mode = 1'b1;
        distance = DIST_W'(dl[0]);
        start_meas(c1);
        last = 0;
        for (int k = 0; k < nwin; k++) begin
            goto(c1 + 200 + PERIOD * k);
            distance = DIST_W'(dl[k + 1]);
            e.disp = model_display(raw_speed(dl[k], dl[k + 1]));
            e.led = 5;
            last = e.disp;
            sb_q.push_back(e);
            goto(c1 + 440 + PERIOD * k);
            pop_compare($sformatf("%s_w%0d", tag, k));
        end
        goto(c1 + 200 + PERIOD * nwin);
        abort_key();
        check({tag, "_abort_led0"}, int'(led[0]), 0);
        read_display(v);
        check({tag, "_hold_disp"}, v, last);
    endtask

    initial begin
        vec_t vecs[5];
        int c1, v;
        exp_t e;
        int seq_a[5];
        int seq_b[5];

        vecs[0] = '{500, 380, 1, 1200, 3};
        vecs[1] = '{200, 260, 1, 600, 5};
        vecs[2] = '{300, 300, 0, 0, 0};
        vecs[3] = '{0, 16383, 1, 9999, 5};
        vecs[4] = '{300, 300, 1, 0, 1};
        seq_a = '{100, 110, 120, 130, 130};
        seq_b = '{0, 40, 120, 200, 280};

        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            mode = vecs[i].m[0];
            distance = DIST_W'(vecs[i].d0);
            e.disp = model_display(vecs[i].speed);
            e.led = vecs[i].led;
            sb_q.push_back(e);
            start_meas(c1);
            distance = DIST_W'(vecs[i].d1);
            if (i == 0) begin
                goto(c1 + 100);
                read_display(v);
                check("first_meas_zero", v, 0);
            end
            goto(c1 + 440);
            pop_compare($sformatf("vec%0d", i));
            if (vecs[i].m != 0) begin
                abort_key();
                check($sformatf("vec%0d_abort_led0", i), int'(led[0]), 0);
            end
        end

        run_cont("cont", seq_a, 3);
        run_cont("avg", seq_b, 4);

        // Reset in the middle of the conversion discards the result
        do_reset();
        mode = 1'b0;
        distance = DIST_W'(500);
        start_meas(c1);
        distance = DIST_W'(380);
        goto(c1 + 407);
        do_reset();
        read_display(v);
        check("rst_conv_disp", v, 0);
        distance = DIST_W'(200);
        e.disp = model_display(600);
        e.led = 4;
        sb_q.push_back(e);
        start_meas(c1);
        distance = DIST_W'(260);
        goto(c1 + 440);
        pop_compare("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
